// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, default timing and keyboard command codes.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    DATA,
    ACK,
    WAIT_IDLE
  } tx_state_t;

  localparam int DEF_INHIBIT_CYCLES = 3000;
  localparam int DEF_TIMEOUT_CYCLES = 375000;
  localparam int DEF_FILTER_LEN     = 8;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] RSP_ACK     = 8'hFA;
  localparam logic [7:0] RSP_BAT_OK  = 8'hAA;

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises and debounces one open-drain PS/2 line; level only moves when the whole
// sample history agrees, and fall pulses once on each filtered 1->0 transition.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk25,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic fall
);

  logic [1:0]            sync;
  logic [FILTER_LEN-1:0] hist;

  always_ff @(posedge clk25) begin
    if (rst) begin
      sync  <= '1;
      hist  <= '1;
      level <= 1'b1;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      hist <= {hist[FILTER_LEN-2:0], sync[1]};
      fall <= 1'b0;
      if (&hist) begin
        level <= 1'b1;
      end else if (~|hist) begin
        level <= 1'b0;
        fall  <= level;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-bit frame on device clocks, ACK check.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
  input  logic       clk25,
  input  logic       rst,
  input  logic       PS2C_in,
  input  logic       PS2D_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       err_noack,
  output logic       err_timeout
);

  localparam logic [11:0] INH_LAST = 12'(INHIBIT_CYCLES - 1);
  localparam logic [11:0] INH_PRE  = 12'(INHIBIT_CYCLES - 2);
  localparam logic [18:0] TO_LAST  = 19'(TIMEOUT_CYCLES - 1);

  tx_state_t   state, state_n;
  logic [11:0] inh_cnt, inh_n;
  logic [18:0] to_cnt, to_n;
  logic [3:0]  bitcnt, bit_n;
  logic [7:0]  sh, sh_n;
  logic        par, par_n;
  logic        c_oe_n, d_oe_n, done_n, noack_n, tout_n;
  logic        c_level, c_fall, d_level, d_fall;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_c (
    .clk25(clk25), .rst(rst), .raw(PS2C_in), .level(c_level), .fall(c_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_d (
    .clk25(clk25), .rst(rst), .raw(PS2D_in), .level(d_level), .fall(d_fall)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk25) begin
    if (rst) begin
      state       <= IDLE;
      inh_cnt     <= '0;
      to_cnt      <= '0;
      bitcnt      <= '0;
      sh          <= '0;
      par         <= 1'b0;
      ps2c_oe     <= 1'b0;
      ps2d_oe     <= 1'b0;
      done        <= 1'b0;
      err_noack   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      inh_cnt     <= inh_n;
      to_cnt      <= to_n;
      bitcnt      <= bit_n;
      sh          <= sh_n;
      par         <= par_n;
      ps2c_oe     <= c_oe_n;
      ps2d_oe     <= d_oe_n;
      done        <= done_n;
      err_noack   <= noack_n;
      err_timeout <= tout_n;
    end
  end

  // Data changes only on filtered clock falls; the device samples on the following rise.
  always_comb begin
    state_n = state;
    inh_n   = inh_cnt;
    to_n    = to_cnt;
    bit_n   = bitcnt;
    sh_n    = sh;
    par_n   = par;
    c_oe_n  = ps2c_oe;
    d_oe_n  = ps2d_oe;
    done_n  = 1'b0;
    noack_n = 1'b0;
    tout_n  = 1'b0;

    case (state)
      IDLE: begin
        c_oe_n = 1'b0;
        d_oe_n = 1'b0;
        if (tx_start) begin
          sh_n    = tx_data;
          par_n   = ~^tx_data;
          bit_n   = '0;
          inh_n   = '0;
          c_oe_n  = 1'b1;
          state_n = INHIBIT;
        end
      end

      INHIBIT: begin
        inh_n = inh_cnt + 12'd1;
        if (inh_cnt == INH_LAST) begin
          c_oe_n  = 1'b0;
          d_oe_n  = 1'b1;
          to_n    = '0;
          state_n = REQ;
        end else if (inh_cnt == INH_PRE) begin
          d_oe_n = 1'b1;
        end
      end

      REQ, DATA, ACK, WAIT_IDLE: begin
        if (to_cnt == TO_LAST) begin
          c_oe_n  = 1'b0;
          d_oe_n  = 1'b0;
          tout_n  = 1'b1;
          state_n = IDLE;
        end else begin
          if (to_cnt != '1) to_n = to_cnt + 19'd1;
          if ((state == REQ || state == DATA) && c_fall) begin
            bit_n = bitcnt + 4'd1;
            if (bitcnt < 4'd8) begin
              d_oe_n  = ~sh[0];
              sh_n    = sh >> 1;
              state_n = DATA;
            end else if (bitcnt == 4'd8) begin
              d_oe_n = ~par;
            end else begin
              d_oe_n  = 1'b0;
              state_n = ACK;
            end
          end else if (state == ACK && c_fall) begin
            bit_n = bitcnt + 4'd1;
            if (!d_level) begin
              state_n = WAIT_IDLE;
            end else begin
              noack_n = 1'b1;
              state_n = IDLE;
            end
          end else if (state == WAIT_IDLE && c_level && d_level) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

  logic unused_d_fall;
  assign unused_d_fall = d_fall;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a wired-AND open-drain bus and a simple keyboard model.
module tb_ps2_host_tx;

  localparam int TB_TIMEOUT = 10000;
  localparam int HALF       = 50;
  localparam int INH_EXP    = 3000;

  logic       clk25 = 1'b0;
  logic       rst;
  logic       ps2c_oe, ps2d_oe;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy, done, err_noack, err_timeout;
  logic       devC, devD, glitch;
  logic       PS2C_in, PS2D_in;

  int assertions = 0;
  int failures   = 0;
  int doneHigh   = 0;
  int noackHigh  = 0;
  int toutHigh   = 0;
  int multiHigh  = 0;

  assign PS2C_in = ~ps2c_oe & devC & ~glitch;
  assign PS2D_in = ~ps2d_oe & devD;

  always #20 clk25 = ~clk25;

  ps2_host_tx #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk25(clk25), .rst(rst), .PS2C_in(PS2C_in), .PS2D_in(PS2D_in),
    .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe), .tx_data(tx_data), .tx_start(tx_start),
    .busy(busy), .done(done), .err_noack(err_noack), .err_timeout(err_timeout)
  );

  always @(negedge clk25) begin
    if (done) doneHigh++;
    if (err_noack) noackHigh++;
    if (err_timeout) toutHigh++;
    if (int'(done) + int'(err_noack) + int'(err_timeout) > 1) multiHigh++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d);
    @(negedge clk25);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk25);
    tx_start = 1'b0;
  endtask

  task automatic waitRequest(output int inhLen, output logic startBit);
    int w = 0;
    while (!ps2c_oe && w < 100) begin
      @(negedge clk25);
      w++;
    end
    inhLen = 0;
    while (ps2c_oe && inhLen < 5000) begin
      inhLen++;
      @(negedge clk25);
    end
    startBit = ps2d_oe;
  endtask

  task automatic runDevice(input int nFalls, input bit giveAck, input int glitchAt,
                           output logic [9:0] bits);
    bits = '0;
    repeat (HALF) @(negedge clk25);
    for (int i = 1; i <= nFalls; i++) begin
      devC = 1'b0;
      repeat (HALF) @(negedge clk25);
      devC = 1'b1;
      if (i <= 10) bits[i-1] = PS2D_in;
      if (i == 10 && giveAck) devD = 1'b0;
      if (i == glitchAt) begin
        repeat (10) @(negedge clk25);
        glitch   = 1'b1;
        tx_data  = 8'h00;
        tx_start = 1'b1;
        @(negedge clk25);
        tx_start = 1'b0;
        repeat (2) @(negedge clk25);
        glitch = 1'b0;
        repeat (HALF - 13) @(negedge clk25);
      end else begin
        repeat (HALF) @(negedge clk25);
      end
    end
    devD = 1'b1;
  endtask

  task automatic runFrame(input logic [7:0] d, input logic [9:0] expBits, input int glitchAt);
    int         inhLen, w, doneBase, errBase;
    logic       startBit;
    logic [9:0] bits;
    applyStimulus(d);
    checkOutput($sformatf("busy_%02h", d), busy, 1'b1);
    waitRequest(inhLen, startBit);
    checkOutput($sformatf("inhibit_len_%02h", d), inhLen, INH_EXP);
    checkOutput($sformatf("start_bit_%02h", d), startBit, 1'b1);
    doneBase = doneHigh;
    errBase  = noackHigh + toutHigh;
    runDevice(11, 1'b1, glitchAt, bits);
    checkOutput($sformatf("frame_bits_%02h", d), bits, expBits);
    w = 0;
    while (busy && w < 200) begin
      @(negedge clk25);
      w++;
    end
    checkOutput($sformatf("busy_drop_%02h", d), busy, 1'b0);
    repeat (20) @(negedge clk25);
    checkOutput($sformatf("done_once_%02h", d), doneHigh - doneBase, 1);
    checkOutput($sformatf("no_err_%02h", d), noackHigh + toutHigh - errBase, 0);
    checkOutput($sformatf("idle_after_%02h", d), busy, 1'b0);
  endtask

  logic [7:0] frameData [4] = '{8'hED, 8'h01, 8'h00, 8'hFF};
  logic [9:0] frameBits [4] = '{10'h3ED, 10'h201, 10'h300, 10'h3FF};

  initial begin
    int         inhLen, n, base, doneBase;
    logic       startBit;
    logic [9:0] bits;

    rst = 1'b1; tx_start = 1'b0; tx_data = 8'h00;
    devC = 1'b1; devD = 1'b1; glitch = 1'b0;
    repeat (5) @(negedge clk25);
    checkOutput("rst_ps2c_oe", ps2c_oe, 1'b0);
    checkOutput("rst_ps2d_oe", ps2d_oe, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_noack", err_noack, 1'b0);
    checkOutput("rst_timeout", err_timeout, 1'b0);
    rst = 1'b0;
    repeat (20) @(negedge clk25);

    for (int i = 0; i < 4; i++) runFrame(frameData[i], frameBits[i], 0);

    // Device withholds the ACK.
    applyStimulus(8'hED);
    waitRequest(inhLen, startBit);
    base     = noackHigh;
    doneBase = doneHigh;
    runDevice(11, 1'b0, 0, bits);
    checkOutput("noack_bits", bits, 10'h3ED);
    checkOutput("noack_pulse", noackHigh - base, 1);
    checkOutput("noack_no_done", doneHigh - doneBase, 0);
    checkOutput("noack_ps2c_oe", ps2c_oe, 1'b0);
    checkOutput("noack_ps2d_oe", ps2d_oe, 1'b0);
    checkOutput("noack_busy", busy, 1'b0);
    repeat (20) @(negedge clk25);

    // Device never clocks after the request.
    applyStimulus(8'hFF);
    waitRequest(inhLen, startBit);
    base = toutHigh;
    n = 0;
    while (!err_timeout && n < TB_TIMEOUT + 100) begin
      @(negedge clk25);
      n++;
    end
    checkOutput("timeout_cycles", n, TB_TIMEOUT);
    checkOutput("timeout_ps2c_oe", ps2c_oe, 1'b0);
    checkOutput("timeout_ps2d_oe", ps2d_oe, 1'b0);
    checkOutput("timeout_busy", busy, 1'b0);
    @(negedge clk25);
    checkOutput("timeout_pulse", toutHigh - base, 1);
    repeat (20) @(negedge clk25);

    // Reset lands mid-frame while the host drives a 0 data bit.
    applyStimulus(8'hA5);
    waitRequest(inhLen, startBit);
    runDevice(5, 1'b1, 0, bits);
    checkOutput("midframe_drive", ps2d_oe, 1'b1);
    rst = 1'b1;
    @(negedge clk25);
    checkOutput("midrst_ps2c_oe", ps2c_oe, 1'b0);
    checkOutput("midrst_ps2d_oe", ps2d_oe, 1'b0);
    checkOutput("midrst_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (20) @(negedge clk25);
    runFrame(8'hFF, 10'h3FF, 0);

    // Ignored tx_start plus a short PS2C glitch during the data phase.
    runFrame(8'hED, 10'h3ED, 4);

    checkOutput("pulse_exclusive", multiHigh, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter: sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset.
- Counterpart to the keyboard receive path. Shares the PS2C/PS2D open-drain lines; the top level builds tristates as "line = oe ? 0 : Z".
- Runs entirely in the clk25 domain. It oversamples and filters the lines, performs the request-to-send sequence, shifts out 11 frame bits on keyboard-generated clocks, and checks the device ACK.

Parameters:
INHIBIT_CYCLES, 3000, clk25 cycles PS2C held low before request (120 us at 25 MHz)
TIMEOUT_CYCLES, 375000, max clk25 cycles from PS2C release to ACK-complete (15 ms)
FILTER_LEN, 8, consecutive equal samples required to change a filtered line level

Ports:
clk25  in  1  system clock, 25 MHz
rst  in  1  synchronous reset, active-high
PS2C_in  in  1  raw PS/2 clock line, asynchronous
PS2D_in  in  1  raw PS/2 data line, asynchronous
ps2c_oe  out  1  1 = drive PS2C low, 0 = release
ps2d_oe  out  1  1 = drive PS2D low, 0 = release
tx_data  in  8  byte to send, captured on accepted tx_start
tx_start  in  1  1-cycle request; accepted only in IDLE, otherwise ignored
busy  out  1  high from the cycle after acceptance until return to IDLE
done  out  1  1-cycle pulse: frame sent and ACK received
err_noack  out  1  1-cycle pulse: ACK bit sampled high
err_timeout  out  1  1-cycle pulse: TIMEOUT_CYCLES exceeded

Behaviour:
- Reset (sync, active-high, one clk25 edge): every output = 0; state = IDLE; counters = 0; filtered lines = 1. Takes effect mid-frame too, releasing both lines on the next edge.
- Filter: FILTER_LEN shift register per line. Filtered level changes only when all samples agree. fall_c = 1-cycle pulse on filtered PS2C 1->0 transition.
- Capture: on acceptance latch sh = tx_data and par = ~^tx_data (odd parity). bitcnt = 0.
- IDLE: both oe = 0. tx_start -> INHIBIT.
- INHIBIT: ps2c_oe = 1, ps2d_oe = 0. Counter runs INHIBIT_CYCLES cycles.
  - Last cycle: ps2d_oe = 1 (start bit). Next cycle ps2c_oe = 0 -> REQ; timeout counter cleared.
- REQ/DATA, data driven only on fall_c (device samples on rising edge):
  - Falls 1-8: ps2d_oe = ~sh[0], sh >> 1 (LSB first).
  - Fall 9: ps2d_oe = ~par.
  - Fall 10: ps2d_oe = 0 (stop bit = release) -> ACK.
- ACK: on fall 11 sample filtered PS2D.
  - 0 -> WAIT_IDLE.
  - 1 -> err_noack pulse, -> IDLE.
- WAIT_IDLE: wait for filtered PS2C = 1 and PS2D = 1 simultaneously, then done pulse -> IDLE.
- Timeout: counter runs in REQ, DATA, ACK and WAIT_IDLE. On reaching TIMEOUT_CYCLES: both oe = 0, err_timeout pulse, -> IDLE. Timeout takes priority over a coincident fall_c.
- Pulse exclusivity: done, err_noack and err_timeout are mutually exclusive. busy is 0 in the pulse cycle's successor.
- Receiver coexistence: the receive path decodes bytes whenever the line toggles. Masking it while busy is the top level's job; this block only drives busy.
- Widths: inhibit counter 12 bits. Timeout counter 19 bits, saturating. bitcnt 4 bits, range 0..11.

Decomposition:
- Package ps2_pkg holds:
  - the state enum IDLE/INHIBIT/REQ/DATA/ACK/WAIT_IDLE
  - localparams for the default cycle counts
  - command/response codes CMD_SET_LED = 8'hED, CMD_RESET = 8'hFF, RSP_ACK = 8'hFA, RSP_BAT_OK = 8'hAA
- Sub-module ps2_line_filter (FILTER_LEN param; outputs level and fall pulse), instantiated twice; reusable by the receive path.

Test Plan:
- tx_data = 0xED, device model clocks at 12.5 kHz and ACKs -> PS2C held low 3000 cycles; bits 1,0,1,1,0,1,1,1 then parity 1 then stop 1 seen on device rising edges; done pulses once; busy drops.
- tx_data = 0x01 -> parity bit 0; tx_data = 0x00 -> parity bit 1; tx_data = 0xFF -> parity bit 1. Each ends with done.
- Device leaves PS2D high on the 11th clock -> err_noack = 1 for exactly 1 cycle; both oe = 0; no done.
- Device never clocks after request -> err_timeout exactly 375000 cycles after PS2C release; both oe = 0; IDLE.
- rst asserted after the 5th falling edge -> next cycle both oe = 0, busy = 0; a fresh tx_start of 0xFF then completes normally.
- tx_start pulsed while busy, plus a 3-cycle glitch on PS2C_in -> start ignored; glitch produces no fall_c; frame unaffected.
